// File: rtl/boa_muldiv_seq.sv
// boa_muldiv_seq: iterative RV32M multiply/divide unit.
// One operand bit is processed per clock (shift-add multiply, restoring
// divide); divide-by-zero and signed overflow are resolved without iterating.
module boa_muldiv_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        d_start,
  input  logic [2:0]  d_funct3,
  input  logic [31:0] d_lhs,
  input  logic [31:0] d_rhs,
  output logic        busy,
  output logic        q_valid,
  output logic [31:0] q_res
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] res_q, res_d;
  logic        load, step;

  // Operation context captured at acceptance
  logic [2:0]  f3_q;
  logic [31:0] opb_q;     // multiplicand (mul) or divisor magnitude (div)
  logic [63:0] acc_q;     // product accumulator; low word is multiplier / dividend-quotient
  logic [32:0] rem_q;     // partial remainder
  logic        qneg_q;    // product / quotient must be negated
  logic        rneg_q;    // remainder must be negated

  // Request decode
  logic        is_div, is_sdiv, lhs_signed, rhs_signed;
  logic        lhs_neg, rhs_neg, div_zero, div_ovf, bypass;
  logic [31:0] lhs_mag, rhs_mag, bypass_res;

  // Iteration datapath
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_sh, div_diff, rem_next;
  logic        div_ge;
  logic [31:0] quo_next;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix, final_res;

  // Decode the incoming request: signedness, magnitudes and special cases
  always_comb begin
    is_div     = d_funct3[2];
    is_sdiv    = (d_funct3 == 3'b100) || (d_funct3 == 3'b110);
    lhs_signed = (d_funct3 == 3'b001) || (d_funct3 == 3'b010) || is_sdiv;
    rhs_signed = (d_funct3 == 3'b001) || is_sdiv;
    lhs_neg    = lhs_signed && d_lhs[31];
    rhs_neg    = rhs_signed && d_rhs[31];
    lhs_mag    = lhs_neg ? (32'd0 - d_lhs) : d_lhs;
    rhs_mag    = rhs_neg ? (32'd0 - d_rhs) : d_rhs;
    div_zero   = is_div && (d_rhs == 32'd0);
    div_ovf    = is_sdiv && (d_lhs == 32'h8000_0000) && (d_rhs == 32'hFFFF_FFFF);
    bypass     = div_zero || div_ovf;
    if (d_funct3[1]) bypass_res = div_zero ? d_lhs : 32'd0;            // REM/REMU
    else             bypass_res = div_zero ? 32'hFFFF_FFFF : 32'h8000_0000; // DIV/DIVU
  end

  // One multiply or divide iteration plus the sign-corrected final result
  always_comb begin
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
    mul_next = {mul_sum, acc_q[31:1]};
    div_sh   = {rem_q[31:0], acc_q[31]};
    div_diff = div_sh - {1'b0, opb_q};
    div_ge   = ~div_diff[32];
    rem_next = div_ge ? div_diff : div_sh;
    quo_next = {acc_q[30:0], div_ge};
    prod_fix = qneg_q ? (64'd0 - mul_next) : mul_next;
    quo_fix  = qneg_q ? (32'd0 - quo_next) : quo_next;
    rem_fix  = rneg_q ? (32'd0 - rem_next[31:0]) : rem_next[31:0];
    case (f3_q)
      3'b000:         final_res = prod_fix[31:0];
      3'b100, 3'b101: final_res = quo_fix;
      3'b110, 3'b111: final_res = rem_fix;
      default:        final_res = prod_fix[63:32];
    endcase
  end

  // Next-state logic; clear overrides acceptance and completion
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    load    = 1'b0;
    step    = 1'b0;
    if (clear) begin
      state_d = IDLE;
      cnt_d   = 5'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (d_start) begin
            load = 1'b1;
            if (bypass) begin
              state_d = DONE;
              res_d   = bypass_res;
            end else begin
              state_d = CALC;
              cnt_d   = 5'd31;
            end
          end
        end
        CALC: begin
          step  = 1'b1;
          cnt_d = cnt_q - 5'd1;
          if (cnt_q == 5'd0) begin
            state_d = DONE;
            cnt_d   = 5'd0;
            res_d   = final_res;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Control state and result register, asynchronously reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      res_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  // Operand latch on acceptance, iteration update while calculating
  always_ff @(posedge clk) begin
    if (load) begin
      f3_q   <= d_funct3;
      opb_q  <= is_div ? rhs_mag : lhs_mag;
      acc_q  <= {32'd0, (is_div ? lhs_mag : rhs_mag)};
      rem_q  <= 33'd0;
      qneg_q <= lhs_neg ^ rhs_neg;
      rneg_q <= lhs_neg;
    end else if (step) begin
      if (f3_q[2]) begin
        acc_q <= {32'd0, quo_next};
        rem_q <= rem_next;
      end else begin
        acc_q <= mul_next;
      end
    end
  end

  assign busy    = (state_q != IDLE);
  assign q_valid = (state_q == DONE);
  assign q_res   = res_q;

endmodule

// File: tb/tb_boa_muldiv_seq.sv
// Directed testbench for boa_muldiv_seq.
module tb_boa_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        d_start;
  logic [2:0]  d_funct3;
  logic [31:0] d_lhs;
  logic [31:0] d_rhs;
  logic        busy;
  logic        q_valid;
  logic [31:0] q_res;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
  localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

  boa_muldiv_seq dut (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .d_start  (d_start),
    .d_funct3 (d_funct3),
    .d_lhs    (d_lhs),
    .d_rhs    (d_rhs),
    .busy     (busy),
    .q_valid  (q_valid),
    .q_res    (q_res)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge, then scramble the operand inputs
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    d_start  = 1'b1;
    d_funct3 = f3;
    d_lhs    = a;
    d_rhs    = b;
    tick();
    d_start  = 1'b0;
    d_funct3 = 3'($urandom);
    d_lhs    = $urandom;
    d_rhs    = $urandom;
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    logic busy_ok;
    issue(f3, a, b);
    lat = 1;
    busy_ok = 1'b1;
    while (!q_valid && lat < 40) begin
      if (!busy) busy_ok = 1'b0;
      tick();
      lat++;
    end
    check({tag, "_res"}, q_res, exp);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy"}, {31'd0, busy_ok}, 32'd1);
    tick();
    check({tag, "_vld1cyc"}, {31'd0, q_valid}, 32'd0);
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int vcount;
    logic [31:0] held;

    rst = 1'b1; clear = 1'b0; d_start = 1'b0;
    d_funct3 = 3'd0; d_lhs = 32'd0; d_rhs = 32'd0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_vld", {31'd0, q_valid}, 32'd0);
    check("rst_res", q_res, 32'd0);
    tick(); tick();
    rst = 1'b0;

    // Divide basics and sign rules
    run_op("div_100_7",  F_DIV,  32'd100, 32'd7, 32'd14, 33);
    run_op("rem_100_7",  F_REM,  32'd100, 32'd7, 32'd2,  33);
    run_op("div_m100_7", F_DIV,  32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 33);
    run_op("rem_m100_7", F_REM,  32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 33);
    run_op("divu_big",   F_DIVU, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 33);

    // Bypass cases
    run_op("divu_5_0",   F_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("remu_5_0",   F_REMU, 32'd5, 32'd0, 32'd5, 1);
    run_op("div_ovf",    F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf",    F_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

    // Multiply
    run_op("mul_2p16",   F_MUL,    32'h0001_0000, 32'h0001_0000, 32'd0, 33);
    run_op("mulhu_2p16", F_MULHU,  32'h0001_0000, 32'h0001_0000, 32'd1, 33);
    run_op("mulh_m1",    F_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 33);
    run_op("mulhsu_m1",  F_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    run_op("mul_7_m3",   F_MUL,    32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    run_op("mulh_min",   F_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);

    // Clear mid-operation
    held = q_res;
    issue(F_DIVU, 32'd1000, 32'd3);
    repeat (8) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_busy", {31'd0, busy}, 32'd0);
    check("clr_vld", {31'd0, q_valid}, 32'd0);
    vcount = 0;
    repeat (40) begin
      tick();
      if (q_valid) vcount++;
    end
    check("clr_no_vld", 32'(vcount), 32'd0);
    check("clr_res_held", q_res, held);
    run_op("divu_9_3", F_DIVU, 32'd9, 32'd3, 32'd3, 33);

    // d_start during CALC is ignored
    issue(F_DIV, 32'd100, 32'd7);
    repeat (4) tick();
    d_start = 1'b1; d_funct3 = F_MUL; d_lhs = 32'd3; d_rhs = 32'd5;
    tick();
    d_start = 1'b0;
    vcount = 0;
    repeat (70) begin
      tick();
      if (q_valid) vcount++;
    end
    check("ign_vld_count", 32'(vcount), 32'd1);
    check("ign_res", q_res, 32'd14);

    // Asynchronous reset mid-CALC
    issue(F_DIVU, 32'd1000, 32'd3);
    repeat (5) tick();
    #2 rst = 1'b1;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_vld", {31'd0, q_valid}, 32'd0);
    check("arst_res", q_res, 32'd0);
    tick();
    rst = 1'b0;
    vcount = 0;
    repeat (40) begin
      tick();
      if (q_valid) vcount++;
    end
    check("arst_no_vld", 32'(vcount), 32'd0);
    run_op("post_rst_remu", F_REMU, 32'd1000, 32'd7, 32'd6, 33);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
